// File: rtl/proc_pkg.sv
// Shared processor definitions: datapath widths, opcode constants and the
// fetch-stage state encoding.
package proc_pkg;

   localparam int IW = 20;
   localparam int AW = 6;

   localparam logic [3:0] OP_RST   = 4'b0010;
   localparam logic [3:0] OP_WRITE = 4'b0011;
   localparam logic [3:0] OP_LOADI = 4'b0100;
   localparam logic [3:0] OP_MUL   = 4'b0101;
   localparam logic [3:0] OP_LOAD  = 4'b0110;
   localparam logic [3:0] OP_MV    = 4'b0111;
   localparam logic [3:0] OP_ADD   = 4'b1000;
   localparam logic [3:0] OP_INC   = 4'b1001;
   localparam logic [3:0] OP_SUB   = 4'b1010;
   localparam logic [3:0] OP_JMPZ  = 4'b1011;
   localparam logic [3:0] OP_JMP   = 4'b1100;
   localparam logic [3:0] OP_STORE = 4'b1101;
   localparam logic [3:0] OP_END   = 4'b1110;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_CAPT   = 3'd2,
      ST_READY  = 3'd3,
      ST_HALTED = 3'd4
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_fetch_pc.sv
// Program counter with next-PC selection: hold, increment (wrapping modulo
// 2**AW) or load of an absolute jump target.
module fetch_pc #(
   parameter int AW = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc_i,
   input  logic          load_i,
   input  logic [AW-1:0] target_i,
   output logic [AW-1:0] pc_o
);

   logic [AW-1:0] pc_q;
   logic [AW-1:0] pc_d;

   // A jump replaces the increment outright; the natural overflow gives the wrap.
   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = target_i;
      end else if (inc_i) begin
         pc_d = pc_q + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC and instruction register, reads one
// instruction per request from a 1-cycle-latency instruction memory.
module instr_fetch_unit #(
   parameter int IW = 20,
   parameter int AW = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          fetch_req,
   input  logic          jump_en,
   input  logic [AW-1:0] jump_target,
   input  logic          halt,
   output logic          imem_rd,
   output logic [AW-1:0] imem_addr,
   input  logic [IW-1:0] imem_rdata,
   output logic [IW-1:0] instruction,
   output logic          instr_valid,
   output logic [AW-1:0] instr_pc,
   output logic          fetch_err
);

   import proc_pkg::*;

   fetch_state_e  state_q;
   fetch_state_e  state_d;
   logic [AW-1:0] pc;
   logic [AW-1:0] addr_q;
   logic [IW-1:0] instr_q;
   logic [AW-1:0] instr_pc_q;
   logic          valid_q;
   logic          err_q;
   logic          pc_inc;
   logic          pc_load;
   logic          busy_req;
   logic          ready_req;

   // Requests arriving while a fetch is still in progress are flagged, never queued.
   assign busy_req  = fetch_req && !halt &&
                      (state_q == ST_IDLE || state_q == ST_REQ || state_q == ST_CAPT);
   assign ready_req = fetch_req && !halt && (state_q == ST_READY);
   assign pc_inc    = (state_q == ST_CAPT) && !halt;
   assign pc_load   = ready_req && jump_en;

   fetch_pc #(
      .AW (AW)
   ) u_fetch_pc (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc_i    (pc_inc),
      .load_i   (pc_load),
      .target_i (jump_target),
      .pc_o     (pc)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (halt) begin
         state_d = ST_HALTED;
      end else begin
         case (state_q)
            ST_IDLE:   state_d = ST_REQ;
            ST_REQ:    state_d = ST_CAPT;
            ST_CAPT:   state_d = ST_READY;
            ST_READY:  state_d = fetch_req ? ST_REQ : ST_READY;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // The address shows the live PC during the read and keeps it afterwards.
   always_comb begin
      imem_rd   = (state_q == ST_REQ) && !halt;
      imem_addr = imem_rd ? pc : addr_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q     <= '0;
         instr_q    <= '0;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         if (imem_rd) begin
            addr_q <= pc;
         end
         if (busy_req) begin
            err_q <= 1'b1;
         end
         if (halt) begin
            valid_q <= 1'b0;
         end else if (state_q == ST_CAPT) begin
            instr_q    <= imem_rdata;
            instr_pc_q <= pc;
            valid_q    <= 1'b1;
         end else if (ready_req) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign instruction = instr_q;
   assign instr_valid = valid_q;
   assign instr_pc    = instr_pc_q;
   assign fetch_err   = err_q;

endmodule
